// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic/shift ops, a radix-2 Booth multiplier
// and an optional restoring divider that is built only when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [4:0]           instruction,
  input  logic [WIDTH-1:0]     Y_in,
  input  logic [WIDTH-1:0]     B_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   C_result,
  output logic                 illegal,
  output logic                 div_zero
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'b10000;
`endif
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef ALU_SEQ_DIV_EN
    DIV  = 2'd2,
`endif
    FIN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [2*WIDTH-1:0]  result_q, result_d;
  logic                illegal_q, illegal_d;
  logic                div_zero_q, div_zero_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]      mcand_q, mcand_d;
  logic [WIDTH:0]      acc_q, acc_d;
  logic [WIDTH-1:0]    mq_q, mq_d;
  logic                qm1_q, qm1_d;
  logic [WIDTH:0]      booth_sum;

`ifdef ALU_SEQ_DIV_EN
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      div_shift, div_trial;
  logic [WIDTH-1:0]    quo_fix, rem_fix;
`endif

  logic [WIDTH-1:0]    alu_res;
  logic                alu_ill;
  logic [SH_W-1:0]     rot_amt, neg_amt;
  logic [WIDTH-1:0]    sra_val;
  logic                big_shift;

  // Single-cycle datapath; shifts honour the full B_in count, rotates use it modulo WIDTH.
  always_comb begin
    rot_amt   = B_in[SH_W-1:0];
    neg_amt   = -rot_amt;
    big_shift = (B_in >= WIDTH_V);
    sra_val   = $signed(Y_in) >>> B_in;
    alu_res   = '0;
    alu_ill   = 1'b0;
    case (instruction)
      OP_ADD, OP_ADDI: alu_res = Y_in + B_in;
      OP_SUB:          alu_res = Y_in - B_in;
      OP_AND, OP_ANDI: alu_res = Y_in & B_in;
      OP_OR, OP_ORI:   alu_res = Y_in | B_in;
      OP_SHR:          alu_res = big_shift ? '0 : (Y_in >> B_in);
      OP_SHRA:         alu_res = big_shift ? {WIDTH{Y_in[WIDTH-1]}} : sra_val;
      OP_SHL:          alu_res = big_shift ? '0 : (Y_in << B_in);
      OP_ROR:          alu_res = (Y_in >> rot_amt) | (Y_in << neg_amt);
      OP_ROL:          alu_res = (Y_in << rot_amt) | (Y_in >> neg_amt);
      OP_NEG:          alu_res = -B_in;
      OP_NOT:          alu_res = ~B_in;
      default:         alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    illegal_d  = illegal_q;
    div_zero_d = div_zero_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    qm1_d      = qm1_q;
    booth_sum  = acc_q;
`ifdef ALU_SEQ_DIV_EN
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    a_mag      = Y_in[WIDTH-1] ? -Y_in : Y_in;
    b_mag      = B_in[WIDTH-1] ? -B_in : B_in;
    div_shift  = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    div_trial  = div_shift - mcand_q;
    quo_fix    = '0;
    rem_fix    = '0;
`endif
    case (state_q)
      MUL: begin
        // Accumulator carries one guard bit so a most-negative multiplicand cannot overflow.
        case ({mq_q[0], qm1_q})
          2'b01:   booth_sum = acc_q + mcand_q;
          2'b10:   booth_sum = acc_q - mcand_q;
          default: booth_sum = acc_q;
        endcase
        acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mq_d  = {booth_sum[0], mq_q[WIDTH-1:1]};
        qm1_d = mq_q[0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d  = FIN;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cnt_d    = '0;
          result_d = {acc_d[WIDTH-1:0], mq_d};
        end
      end
`ifdef ALU_SEQ_DIV_EN
      DIV: begin
        if (!div_trial[WIDTH]) begin
          acc_d = div_trial;
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift;
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          quo_fix  = neg_quo_q ? -mq_d : mq_d;
          rem_fix  = neg_rem_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
          state_d  = FIN;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cnt_d    = '0;
          result_d = {rem_fix, quo_fix};
        end
      end
`endif
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          illegal_d  = 1'b0;
          div_zero_d = 1'b0;
          cnt_d      = CNT_W'(WIDTH - 1);
          if (instruction == OP_MUL) begin
            state_d = MUL;
            busy_d  = 1'b1;
            mcand_d = {Y_in[WIDTH-1], Y_in};
            acc_d   = '0;
            mq_d    = B_in;
            qm1_d   = 1'b0;
          end
`ifdef ALU_SEQ_DIV_EN
          else if (instruction == OP_DIV && B_in == '0) begin
            state_d    = FIN;
            done_d     = 1'b1;
            cnt_d      = '0;
            div_zero_d = 1'b1;
            result_d   = {Y_in, {WIDTH{1'b1}}};
          end else if (instruction == OP_DIV) begin
            state_d   = DIV;
            busy_d    = 1'b1;
            mcand_d   = {1'b0, b_mag};
            acc_d     = '0;
            mq_d      = a_mag;
            neg_quo_d = Y_in[WIDTH-1] ^ B_in[WIDTH-1];
            neg_rem_d = Y_in[WIDTH-1];
          end
`endif
          else begin
            state_d   = FIN;
            done_d    = 1'b1;
            cnt_d     = '0;
            illegal_d = alu_ill;
            result_d  = {{WIDTH{1'b0}}, alu_res};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      illegal_q  <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      qm1_q      <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      illegal_q  <= illegal_d;
      div_zero_q <= div_zero_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      qm1_q      <= qm1_d;
`ifdef ALU_SEQ_DIV_EN
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign C_result = result_q;
  assign illegal  = illegal_q;
  assign div_zero = div_zero_q;

endmodule
